// File: rtl/dm_stage.sv
// dm_stage -- memory (M) to write-back (W) pipeline stage with a word-organised
// data memory.
//
// Decodes the M-stage opcode, performs byte/halfword/word loads and stores
// against a DM_WORDS x 32 little-endian array, and registers the extended
// load result, an address-error flag and the passthrough fields into W.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   synchronous active-high reset (clears W regs and memory)
//   InstructionM in   32  M-stage instruction, opcode in [31:26]
//   ALUOutM      in   32  byte address for loads/stores, result otherwise
//   ReadData2M   in   32  store data (rt)
//   WriteRegM    in   5   destination register
//   PCouter8M    in   32  PC+8
//   InstructionW out  32  registered InstructionM
//   ALUOutW      out  32  registered ALUOutM
//   PCouter8W    out  32  registered PCouter8M
//   WriteRegW    out  5   registered WriteRegM
//   ReadDataW    out  32  registered extended load data (0 for non-loads/errors)
//   AddrErrW     out  1   registered misaligned/out-of-range flag
//
// Handshake: none. The stage advances every cycle; there is no valid/ready,
// stall or flush, so each M input is consumed at every rising edge.
module dm_stage #(
    parameter int DM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] InstructionM,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] ReadData2M,
    input  logic [4:0]  WriteRegM,
    input  logic [31:0] PCouter8M,
    output logic [31:0] InstructionW,
    output logic [31:0] ALUOutW,
    output logic [31:0] PCouter8W,
    output logic [4:0]  WriteRegW,
    output logic [31:0] ReadDataW,
    output logic        AddrErrW
);

    localparam int          AW         = (DM_WORDS > 1) ? $clog2(DM_WORDS) : 1;
    localparam logic [31:0] BYTE_LIMIT = 32'(4 * DM_WORDS);

    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SB  = 6'b101000;

    logic [31:0] mem_q [DM_WORDS];

    logic [31:0] instr_q, instr_d;
    logic [31:0] alu_q, alu_d;
    logic [31:0] pc8_q, pc8_d;
    logic [4:0]  wreg_q, wreg_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [5:0]    opcode;
    logic          is_load, is_store, is_word, is_half, is_signed;
    logic          in_range, misaligned, addr_err;
    logic [AW-1:0] word_idx;
    logic [1:0]    byte_off;
    logic [31:0]   rd_word;
    logic [7:0]    sel_byte;
    logic [15:0]   sel_half;
    logic          wr_en;
    logic [31:0]   wr_word;

    always_comb begin
        opcode    = InstructionM[31:26];
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_word   = 1'b0;
        is_half   = 1'b0;
        is_signed = 1'b0;
        case (opcode)
            OP_LW:  begin is_load  = 1'b1; is_word = 1'b1; end
            OP_LH:  begin is_load  = 1'b1; is_half = 1'b1; is_signed = 1'b1; end
            OP_LHU: begin is_load  = 1'b1; is_half = 1'b1; end
            OP_LB:  begin is_load  = 1'b1; is_signed = 1'b1; end
            OP_LBU: begin is_load  = 1'b1; end
            OP_SW:  begin is_store = 1'b1; is_word = 1'b1; end
            OP_SH:  begin is_store = 1'b1; is_half = 1'b1; end
            OP_SB:  begin is_store = 1'b1; end
            default: ;
        endcase

        byte_off   = ALUOutM[1:0];
        word_idx   = ALUOutM[AW+1:2];
        in_range   = (ALUOutM < BYTE_LIMIT);
        misaligned = (is_word && (byte_off != 2'b00)) || (is_half && byte_off[0]);
        addr_err   = (is_load || is_store) && (!in_range || misaligned);

        // Guarded read keeps the index inside the array for any DM_WORDS.
        rd_word = in_range ? mem_q[word_idx] : 32'h0;

        case (byte_off)
            2'd0:    sel_byte = rd_word[7:0];
            2'd1:    sel_byte = rd_word[15:8];
            2'd2:    sel_byte = rd_word[23:16];
            default: sel_byte = rd_word[31:24];
        endcase
        sel_half = byte_off[1] ? rd_word[31:16] : rd_word[15:0];

        // Store merge: start from the current word so unaddressed lanes hold.
        wr_en   = is_store && !addr_err;
        wr_word = rd_word;
        if (is_word) begin
            wr_word = ReadData2M;
        end else if (is_half) begin
            if (byte_off[1]) wr_word[31:16] = ReadData2M[15:0];
            else             wr_word[15:0]  = ReadData2M[15:0];
        end else begin
            case (byte_off)
                2'd0:    wr_word[7:0]   = ReadData2M[7:0];
                2'd1:    wr_word[15:8]  = ReadData2M[7:0];
                2'd2:    wr_word[23:16] = ReadData2M[7:0];
                default: wr_word[31:24] = ReadData2M[7:0];
            endcase
        end

        rdata_d = 32'h0;
        if (is_load && !addr_err) begin
            if (is_word)      rdata_d = rd_word;
            else if (is_half) rdata_d = {{16{is_signed & sel_half[15]}}, sel_half};
            else              rdata_d = {{24{is_signed & sel_byte[7]}}, sel_byte};
        end

        err_d   = addr_err;
        instr_d = InstructionM;
        alu_d   = ALUOutM;
        pc8_d   = PCouter8M;
        wreg_d  = WriteRegM;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q <= '0;
            alu_q   <= '0;
            pc8_q   <= '0;
            wreg_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            instr_q <= instr_d;
            alu_q   <= alu_d;
            pc8_q   <= pc8_d;
            wreg_q  <= wreg_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Memory clears on reset; a store in M during reset is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DM_WORDS; i++) mem_q[i] <= '0;
        end else if (wr_en) begin
            mem_q[word_idx] <= wr_word;
        end
    end

    assign InstructionW = instr_q;
    assign ALUOutW      = alu_q;
    assign PCouter8W    = pc8_q;
    assign WriteRegW    = wreg_q;
    assign ReadDataW    = rdata_q;
    assign AddrErrW     = err_q;

endmodule

// File: doc/dm_stage.md
DM_STAGE -- requirements
Module: dm_stage

Interface
REQ-001 Parameter DM_WORDS, default 1024, number of 32-bit data-memory words; the byte range is 0 to 4*DM_WORDS-1.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 InstructionM  input  32  instruction in the M stage; opcode is [31:26].
REQ-005 ALUOutM  input  32  effective byte address for loads/stores; passthrough result for other instructions.
REQ-006 ReadData2M  input  32  store data (rt value).
REQ-007 WriteRegM  input  5  destination register number.
REQ-008 PCouter8M  input  32  PC+8 of the instruction.
REQ-009 InstructionW, ALUOutW, PCouter8W  output  32 each  registered copies of the M-stage inputs.
REQ-010 WriteRegW  output  5  registered WriteRegM.
REQ-011 ReadDataW  output  32  registered, extended load result.
REQ-012 AddrErrW  output  1  registered flag: the M-stage load/store was misaligned or out of range.

Function
REQ-013 Opcode decode: lw 100011, lh 100001, lhu 100101, lb 100000, lbu 100100, sw 101011, sh 101001, sb 101000; every other opcode is a non-memory op.
REQ-014 Storage is DM_WORDS x 32 bits; word index is ALUOutM[11:2] for the default depth, generally ALUOutM[log2(DM_WORDS)+1:2].
REQ-015 Byte lanes are little-endian: offset 0 maps to bits [7:0] and offset 3 maps to bits [31:24]; halfword offset 0 maps to bits [15:0] and offset 2 maps to bits [31:16].
REQ-016 Error conditions:
  - Out of range: address >= 4*DM_WORDS.
  - Misaligned word: lw/sw with address[1:0] != 0.
  - Misaligned halfword: lh/lhu/sh with address[0] = 1.
  - Byte accesses are never misaligned.
REQ-017 A store with no error writes at the rising edge that ends its M cycle.
  - sw writes all 4 lanes.
  - sh writes ReadData2M[15:0] into the addressed halfword only.
  - sb writes ReadData2M[7:0] into the addressed byte only.
  - Unaddressed lanes are unchanged.
REQ-018 A store with an error writes nothing.
REQ-019 Loads read the array combinationally during M; the extended result is registered into ReadDataW at the same edge, giving a latency of 1 cycle from M to W.
REQ-020 Load extension:
  - lw: full word.
  - lh: sign-extend the selected halfword; lhu: zero-extend it.
  - lb: sign-extend the selected byte; lbu: zero-extend it.
REQ-021 A load with an error, and any non-load instruction, registers ReadDataW = 0.
REQ-022 AddrErrW registers 1 only for a load/store meeting REQ-016; otherwise it registers 0.
REQ-023 Store-then-load to the same address in consecutive cycles returns the newly stored data: the write completes before the load's M cycle.
REQ-024 InstructionW, ALUOutW, PCouter8W and WriteRegW register their M inputs every cycle, unconditionally; there is no stall or flush input.

Reset
REQ-025 While reset = 1 at a rising edge:
  - All W outputs and AddrErrW become 0.
  - Every memory word becomes 0.
  - No store takes effect, even if a store is in M.
REQ-026 The first edge with reset = 0 resumes normal operation with no extra latency.

Verification
REQ-027 Word round trip: sw 0x12345678 @0x10, then lw @0x10 next cycle -> ReadDataW = 0x12345678, AddrErrW = 0.
REQ-028 Byte/half lanes, starting from word @0x20 = 0xFFFFFFFF:
  - sb 0x00 @0x21, then lw @0x20 -> 0xFFFF00FF.
  - lb @0x23 -> 0xFFFFFFFF.
  - lbu @0x23 -> 0x000000FF.
  - sh 0x8001 @0x22, then lh @0x22 -> 0xFFFF8001 and lhu @0x22 -> 0x00008001.
REQ-029 Misaligned accesses:
  - sw 0xDEADBEEF @0x31 -> AddrErrW = 1 and the word @0x30 is unchanged.
  - lh @0x33 -> ReadDataW = 0, AddrErrW = 1.
REQ-030 Out of range with DM_WORDS = 1024: sw @0x1000 -> AddrErrW = 1, no word modified (the word @0x0 is unchanged); lw @0x1000 -> ReadDataW = 0.
REQ-031 Passthrough: an addu with ALUOutM = 0xCAFEF00D, WriteRegM = 5, PCouter8M = 0x3008 -> next cycle ALUOutW = 0xCAFEF00D, WriteRegW = 5, PCouter8W = 0x3008, ReadDataW = 0, AddrErrW = 0.
REQ-032 Reset mid-operation:
  - Assert reset in the same cycle a sw 0x1 @0x40 is in M -> all outputs 0 and a subsequent lw @0x40 returns 0.
  - A word written before reset reads 0 after reset.
